// File: rtl/time_keeper.sv
// 12-hour real-time clock with a button-driven edit FSM for hour, minute, AM/PM and feed duration.
// Optional cursor blink is enabled by defining TIME_BLINK_EN.
module time_keeper #(
    parameter int TICKS_PER_SEC = 25000000,
    parameter int BLINK_TICKS   = 6250000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        edit_en,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_sel,
    output logic [7:0]  hour,
    output logic [7:0]  min,
    output logic        ampm,
    output logic [31:0] dur,
    output logic [1:0]  field,
    output logic        editing,
    output logic        min_tick,
    output logic        blink
);

    typedef enum logic [2:0] {RUN, E_HOUR, E_MIN, E_AMPM, E_DUR} state_t;

    localparam logic [31:0] TICK_LAST  = 32'(TICKS_PER_SEC - 1);
    localparam logic [31:0] BLINK_LAST = 32'(BLINK_TICKS - 1);

    function automatic logic [3:0] hour_inc(input logic [3:0] h);
        return (h == 4'd12) ? 4'd1 : h + 4'd1;
    endfunction

    function automatic logic [3:0] hour_dec(input logic [3:0] h);
        return (h == 4'd1) ? 4'd12 : h - 4'd1;
    endfunction

    function automatic logic [3:0] dur_up(input logic [3:0] d);
        case (d)
            4'd5:    return 4'd8;
            4'd8:    return 4'd11;
            default: return 4'd5;
        endcase
    endfunction

    function automatic logic [3:0] dur_dn(input logic [3:0] d);
        case (d)
            4'd5:    return 4'd11;
            4'd11:   return 4'd8;
            default: return 4'd5;
        endcase
    endfunction

    state_t      state_r, state_nxt_s;
    logic        up_prev_r, dn_prev_r, sel_prev_r, edit_prev_r;
    logic        up_raw_s, dn_raw_s, up_p_s, dn_p_s, sel_p_s, edit_rise_s, act_s;
    logic [31:0] tick_r;
    logic [5:0]  sec_r;
    logic [3:0]  hour_r;
    logic [5:0]  min_r;
    logic        ampm_r;
    logic [3:0]  dur_r;
    logic [1:0]  field_r;
    logic        editing_r;
    logic        min_tick_r;

    // Rising-edge detection; sel beats up/down, up with down cancels out
    always_comb begin
        up_raw_s    = btn_up & ~up_prev_r;
        dn_raw_s    = btn_down & ~dn_prev_r;
        sel_p_s     = btn_sel & ~sel_prev_r;
        up_p_s      = up_raw_s & ~dn_raw_s & ~sel_p_s;
        dn_p_s      = dn_raw_s & ~up_raw_s & ~sel_p_s;
        edit_rise_s = edit_en & ~edit_prev_r;
        act_s       = (state_r != RUN) & edit_en;
    end

    // Button and edit_en history registers
    always_ff @(posedge clk) begin
        if (reset) begin
            up_prev_r   <= 1'b0;
            dn_prev_r   <= 1'b0;
            sel_prev_r  <= 1'b0;
            edit_prev_r <= 1'b0;
        end else begin
            up_prev_r   <= btn_up;
            dn_prev_r   <= btn_down;
            sel_prev_r  <= btn_sel;
            edit_prev_r <= edit_en;
        end
    end

    // Next-state logic; leaving edit mode overrides any same-cycle press
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN:     if (edit_rise_s) state_nxt_s = E_HOUR; else state_nxt_s = RUN;
            E_HOUR:  if (!edit_en) state_nxt_s = RUN; else if (sel_p_s) state_nxt_s = E_MIN;  else state_nxt_s = E_HOUR;
            E_MIN:   if (!edit_en) state_nxt_s = RUN; else if (sel_p_s) state_nxt_s = E_AMPM; else state_nxt_s = E_MIN;
            E_AMPM:  if (!edit_en) state_nxt_s = RUN; else if (sel_p_s) state_nxt_s = E_DUR;  else state_nxt_s = E_AMPM;
            E_DUR:   if (!edit_en) state_nxt_s = RUN; else if (sel_p_s) state_nxt_s = E_HOUR; else state_nxt_s = E_DUR;
            default: state_nxt_s = RUN;
        endcase
    end

    // State register plus cursor/editing outputs lagging the state by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= RUN;
            field_r   <= 2'd0;
            editing_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            editing_r <= (state_r != RUN);
            case (state_r)
                E_MIN:   field_r <= 2'd1;
                E_AMPM:  field_r <= 2'd2;
                E_DUR:   field_r <= 2'd3;
                default: field_r <= 2'd0;
            endcase
        end
    end

    // Timekeeping in RUN; counters frozen at zero around and during edit
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_r     <= 32'd0;
            sec_r      <= 6'd0;
            hour_r     <= 4'd12;
            min_r      <= 6'd0;
            ampm_r     <= 1'b0;
            dur_r      <= 4'd5;
            min_tick_r <= 1'b0;
        end else begin
            min_tick_r <= 1'b0;
            if ((state_r != RUN) || (state_nxt_s != RUN)) begin
                tick_r <= 32'd0;
                sec_r  <= 6'd0;
                if (act_s) begin
                    case (state_r)
                        E_HOUR: if (up_p_s) hour_r <= hour_inc(hour_r);
                                else if (dn_p_s) hour_r <= hour_dec(hour_r);
                        E_MIN:  if (up_p_s) min_r <= (min_r == 6'd59) ? 6'd0 : min_r + 6'd1;
                                else if (dn_p_s) min_r <= (min_r == 6'd0) ? 6'd59 : min_r - 6'd1;
                        E_AMPM: if (up_p_s | dn_p_s) ampm_r <= ~ampm_r;
                        E_DUR:  if (up_p_s) dur_r <= dur_up(dur_r);
                                else if (dn_p_s) dur_r <= dur_dn(dur_r);
                        default: ;
                    endcase
                end
            end else if (tick_r == TICK_LAST) begin
                tick_r <= 32'd0;
                if (sec_r == 6'd59) begin
                    sec_r      <= 6'd0;
                    min_tick_r <= 1'b1;
                    if (min_r == 6'd59) begin
                        min_r  <= 6'd0;
                        hour_r <= hour_inc(hour_r);
                        if (hour_r == 4'd11) ampm_r <= ~ampm_r;
                    end else begin
                        min_r <= min_r + 6'd1;
                    end
                end else begin
                    sec_r <= sec_r + 6'd1;
                end
            end else begin
                tick_r <= tick_r + 32'd1;
            end
        end
    end

`ifdef TIME_BLINK_EN
    logic [31:0] blink_cnt_r;
    logic        blink_r;

    // Blink phase; any value change or entry to the hour field restarts it solid
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_r <= 32'd0;
            blink_r     <= 1'b1;
        end else if ((state_r == RUN) || !edit_en ||
                     (act_s && (up_p_s || dn_p_s)) ||
                     (state_r == E_DUR && sel_p_s)) begin
            blink_cnt_r <= 32'd0;
            blink_r     <= 1'b1;
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r <= 32'd0;
            blink_r     <= ~blink_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + 32'd1;
        end
    end

    assign blink = blink_r;
`else
    assign blink = 1'b1 | (BLINK_LAST == 32'd0);
`endif

    assign hour     = {4'd0, hour_r};
    assign min      = {2'd0, min_r};
    assign ampm     = ampm_r;
    assign dur      = {28'd0, dur_r};
    assign field    = field_r;
    assign editing  = editing_r;
    assign min_tick = min_tick_r;

endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench for time_keeper: expectations are queued with the stimulus and checked after settling.
module tb_time_keeper;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        edit_en = 1'b0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_sel = 1'b0;
    logic [7:0]  hour, min;
    logic        ampm, editing, min_tick, blink;
    logic [31:0] dur;
    logic [1:0]  field;

    int n_cmp = 0;
    int n_err = 0;
    int pulses = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    time_keeper #(.TICKS_PER_SEC(4), .BLINK_TICKS(3)) dut (
        .clk(clk), .reset(reset), .edit_en(edit_en),
        .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
        .hour(hour), .min(min), .ampm(ampm), .dur(dur),
        .field(field), .editing(editing), .min_tick(min_tick), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs(input string tag);
        case (tag)
            "hour":     return {24'd0, hour};
            "min":      return {24'd0, min};
            "ampm":     return {31'd0, ampm};
            "dur":      return dur;
            "field":    return {30'd0, field};
            "editing":  return {31'd0, editing};
            "min_tick": return {31'd0, min_tick};
            "blink":    return {31'd0, blink};
            "pulses":   return 32'(pulses);
            default:    return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, obs(e.tag), e.exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mask bit0 = up, bit1 = down, bit2 = sel
    task automatic press(input logic [2:0] mask);
        btn_up   = mask[0];
        btn_down = mask[1];
        btn_sel  = mask[2];
        tick(1);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_sel  = 1'b0;
        tick(3);
    endtask

    task automatic wait_min_tick();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick(1);
            if (min_tick) seen = 1'b1;
        end
        check_val("min_tick_wait", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        // Reset state
        tick(3);
        push("hour", 12); push("min", 0); push("ampm", 0); push("dur", 5);
        push("field", 0); push("editing", 0); push("min_tick", 0); push("blink", 1);
        drain();

        // One minute of run mode
        reset = 1'b0;
        for (int i = 0; i < 245; i++) begin
            tick(1);
            if (min_tick) pulses++;
        end
        push("pulses", 1); push("min", 1); push("hour", 12); push("ampm", 0);
        drain();

        // Preload 11:59 AM and roll over to 12:00 PM
        edit_en = 1'b1;
        tick(3);
        push("field", 0); push("editing", 1);
        drain();
        press(3'b010);
        press(3'b100);
        press(3'b010);
        press(3'b010);
        edit_en = 1'b0;
        tick(3);
        push("hour", 11); push("min", 59); push("ampm", 0); push("editing", 0);
        drain();
        wait_min_tick();
        push("hour", 12); push("min", 0); push("ampm", 1);
        drain();

        // Preload 12:59 PM and roll over to 1:00 PM
        edit_en = 1'b1;
        tick(3);
        press(3'b100);
        press(3'b010);
        edit_en = 1'b0;
        tick(3);
        push("hour", 12); push("min", 59); push("ampm", 1);
        drain();
        wait_min_tick();
        push("hour", 1); push("min", 0); push("ampm", 1);
        drain();

        // Hour editing: held button steps once, wrap both ways
        edit_en = 1'b1;
        tick(3);
        push("field", 0); push("editing", 1);
        press(3'b010);
        push("hour", 12);
        drain();
        btn_up = 1'b1;
        tick(10);
        btn_up = 1'b0;
        tick(3);
        push("hour", 1);
        drain();
        press(3'b010); push("hour", 12); drain();
        press(3'b010); push("hour", 11); drain();
        press(3'b010); push("hour", 10); drain();

        // Cursor walk, ampm toggle, dur cycle and simultaneous presses
        press(3'b100); push("field", 1); drain();
        press(3'b100); push("field", 2); drain();
        press(3'b001); push("ampm", 0); drain();
        press(3'b010); push("ampm", 1); drain();
        press(3'b100); push("field", 3); drain();
        press(3'b001); push("dur", 8); drain();
        press(3'b001); push("dur", 11); drain();
        press(3'b001); push("dur", 5); drain();
        press(3'b011); push("dur", 5); drain();
        press(3'b101); push("field", 0); push("hour", 10); push("dur", 5); drain();

        // Minute wrap downward, then exit with a same-cycle up press
        press(3'b100);
        push("field", 1); push("min", 0);
        drain();
        press(3'b010); push("min", 59); push("hour", 10); drain();
        edit_en = 1'b0;
        btn_up  = 1'b1;
        tick(1);
        btn_up  = 1'b0;
        tick(2);
        push("min", 59); push("editing", 0); push("field", 0); push("hour", 10);
        drain();

        // Reset in the middle of editing dur
        edit_en = 1'b1;
        tick(3);
        press(3'b100);
        press(3'b100);
        press(3'b100);
        press(3'b001);
        press(3'b001);
        push("field", 3); push("dur", 11);
        drain();
        reset   = 1'b1;
        edit_en = 1'b0;
        tick(1);
        push("hour", 12); push("min", 0); push("ampm", 0); push("dur", 5);
        push("field", 0); push("editing", 0); push("blink", 1);
        drain();
        reset = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
- Real-time clock and time-setting controller that drives the hour/minute/AM-PM and feed-duration values consumed by the VGA idle-screen renderer.
- Keeps 12-hour time in run mode.
- In edit mode it takes debounced button levels and steps a cursor through the hour, minute, AM/PM and duration fields, with wrap-around arithmetic.
- Outputs the cursor position so the renderer can highlight the active field.

Parameters:
- TICKS_PER_SEC, 25000000, clk cycles per second (sim benches use 4).
- BLINK_TICKS, 6250000, clk cycles per blink half-period (only used with TIME_BLINK_EN).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- edit_en  input  1  level; high = edit mode requested (menu state bit).
- btn_up  input  1  debounced button level, increment.
- btn_down  input  1  debounced button level, decrement.
- btn_sel  input  1  debounced button level, advance cursor.
- hour  output  8  binary 1..12.
- min  output  8  binary 0..59.
- ampm  output  1  0 = AM, 1 = PM.
- dur  output  32  feed duration; only values 5, 8 or 11.
- field  output  2  cursor: 0 hour, 1 min, 2 ampm, 3 dur; 0 outside edit.
- editing  output  1  high while FSM is in any EDIT state.
- min_tick  output  1  one-cycle pulse when run-mode time advances a minute.
- blink  output  1  cursor blink phase (see Optional Feature).

Behaviour:
- Reset values: hour=12, min=0, ampm=0, dur=5, field=0, editing=0, min_tick=0, blink=1.
- Reset also clears the tick and second counters, the edge-detect registers and the FSM (to RUN).
- Reset mid-edit discards all edits and forces the reset values.
- Edge detect: each button is registered once. A press is the rising edge (cur & ~prev) and is acted on in the following cycle. A held button gives exactly one action.
- Simultaneous presses in one cycle:
  - sel with up/down: sel wins, up/down ignored.
  - up with down: both ignored.
- FSM states: RUN, E_HOUR, E_MIN, E_AMPM, E_DUR.
  - RUN -> E_HOUR on edit_en rising edge.
  - E_HOUR -> E_MIN -> E_AMPM -> E_DUR -> E_HOUR on each sel press.
  - Any EDIT state -> RUN when edit_en is low, checked every cycle. Exit takes priority over a same-cycle button press, which is dropped.
  - field and editing are registered outputs; they reflect the state one cycle after the transition.
- Run mode:
  - Tick counter counts 0..TICKS_PER_SEC-1. At terminal count the seconds counter increments 0..59.
  - On the seconds 59->0 wrap, min increments and min_tick pulses for exactly 1 cycle, coincident with the output update.
  - min 59->0 increments hour.
  - hour 11->12 toggles ampm; hour 12->1 leaves ampm unchanged.
- Edit mode:
  - Tick and second counters are held at 0; the clock does not advance and min_tick stays 0.
  - On return to RUN the counters restart from 0, so a full minute elapses before the first min_tick.
- Edit arithmetic, with no carry between fields:
  - hour: up 12->1, down 1->12; ampm unchanged.
  - min: up 59->0, down 0->59; hour unchanged.
  - ampm: up or down toggles.
  - dur: up 5->8->11->5, down 5->11->8->5.
- dur upper bits [31:4] are always 0.
- edit_en rising while already in EDIT has no effect.

Optional Feature:
- Macro: TIME_BLINK_EN.
- Defined:
  - Blink counter counts 0..BLINK_TICKS-1 and toggles blink at terminal count while editing=1.
  - Any up or down press, or entry to E_HOUR, reloads the counter to 0 and sets blink=1, so a value just changed is shown solid.
  - In RUN, blink=1 and the counter is held at 0.
- Not defined: blink is tied to 1 and no counter is synthesised.

Test Plan:
- Reset then 60*TICKS_PER_SEC (=240) cycles in RUN -> min=1, hour=12, ampm=0, exactly one min_tick pulse.
- Preload 11:59 AM via edit, exit, run 240 cycles -> hour=12, min=0, ampm=1. Repeat from 12:59 PM -> hour=1, min=0, ampm=1.
- edit_en=1 -> field=0, editing=1. Hold btn_up for 10 cycles -> hour 12->1, exactly one step. btn_down once -> hour=12. Two more down presses -> hour=11, then 10.
- Cursor to dur (3 sel presses, field 1,2,3), then up x3 -> dur 8, 11, 5. Press up and down in the same cycle -> dur unchanged. Press sel and up together -> field=0, hour unchanged.
- In E_MIN at min=0, press down -> min=59, hour unchanged. Drop edit_en with btn_up rising in the same cycle -> RUN, min stays 59, editing=0 next cycle.
- Assert reset while in E_DUR with dur=11 -> next cycle: 12:00 AM, dur=5, field=0, editing=0. Optionally with TIME_BLINK_EN and BLINK_TICKS=3: blink toggles every 3 cycles while editing and returns to 1 on each up press.
